// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory read/write port between the core
// data path and an external requester (loader / debug DMA).
//
// Ports
//   clk, rst            : clock, synchronous active-high reset
//   core_req/addr/we/wdata -> core_gnt, core_rvalid, core_rdata
//   ext_req/addr/we/wdata/lock -> ext_gnt, ext_rvalid, ext_rdata
//   mem_A, mem_WE, mem_W : memory port drive; mem_R : read data (+1 cycle)
//   lock_active          : external burst lock held
//   core_stall           : core requesting but not granted
//
// Arbitration is round-robin between the two requesters. The external
// requester may hold the port for a burst via ext_lock, but a burst is
// cut after MAX_BURST beats so the core cannot be starved.

module mem_port_arbiter #(
    parameter int WORD_WIDTH = 32,
    parameter int WE_WIDTH   = 4,
    parameter int MAX_BURST  = 8
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  core_req,
    input  logic [WORD_WIDTH-1:0] core_addr,
    input  logic [WE_WIDTH-1:0]   core_we,
    input  logic [WORD_WIDTH-1:0] core_wdata,
    output logic                  core_gnt,
    output logic                  core_rvalid,
    output logic [WORD_WIDTH-1:0] core_rdata,

    input  logic                  ext_req,
    input  logic [WORD_WIDTH-1:0] ext_addr,
    input  logic [WE_WIDTH-1:0]   ext_we,
    input  logic [WORD_WIDTH-1:0] ext_wdata,
    input  logic                  ext_lock,
    output logic                  ext_gnt,
    output logic                  ext_rvalid,
    output logic [WORD_WIDTH-1:0] ext_rdata,

    output logic [WORD_WIDTH-1:0] mem_A,
    output logic [WE_WIDTH-1:0]   mem_WE,
    output logic [WORD_WIDTH-1:0] mem_W,
    input  logic [WORD_WIDTH-1:0] mem_R,

    output logic                  lock_active,
    output logic                  core_stall
);

    localparam int CW = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_BURST);
    // A one-beat burst limit means a lock could never outlive its
    // first beat, so locking is disabled outright.
    localparam logic LOCK_EN = (MAX_BURST > 1);

    typedef enum logic {
        S_ARB,
        S_LOCK
    } state_e;

    typedef enum logic {
        OWN_CORE,
        OWN_EXT
    } owner_e;

    state_e        state_q, state_d;
    owner_e        last_owner_q, last_owner_d;
    logic [CW-1:0] burst_cnt_q, burst_cnt_d;
    logic          core_rd_pend_q, core_rd_pend_d;
    logic          ext_rd_pend_q, ext_rd_pend_d;

    // Raw grants before the reset mask.
    logic          core_win;
    logic          ext_win;
    logic          both_req;
    logic [CW-1:0] cnt_inc;
    logic          core_is_read;
    logic          ext_is_read;

    assign both_req     = core_req & ext_req;
    assign cnt_inc      = burst_cnt_q + CNT_ONE;
    assign core_is_read = (core_we == '0);
    assign ext_is_read  = (ext_we == '0);

    // ------------------------------------------------------------
    // Grant decision
    // ------------------------------------------------------------
    always_comb begin
        core_win = 1'b0;
        ext_win  = 1'b0;
        case (state_q)
            S_ARB: begin
                if (both_req) begin
                    // Tie goes to whoever did not own the last beat.
                    core_win = (last_owner_q == OWN_EXT);
                    ext_win  = (last_owner_q == OWN_CORE);
                end else begin
                    core_win = core_req;
                    ext_win  = ext_req;
                end
            end
            S_LOCK: begin
                ext_win = ext_req;
            end
            default: begin
                core_win = 1'b0;
                ext_win  = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------
    always_comb begin
        state_d        = state_q;
        last_owner_d   = last_owner_q;
        burst_cnt_d    = burst_cnt_q;
        core_rd_pend_d = core_win & core_is_read;
        ext_rd_pend_d  = ext_win & ext_is_read;

        if (core_win) begin
            last_owner_d = OWN_CORE;
        end
        if (ext_win) begin
            last_owner_d = OWN_EXT;
        end

        case (state_q)
            S_ARB: begin
                if (ext_win && ext_lock && LOCK_EN) begin
                    state_d     = S_LOCK;
                    burst_cnt_d = CNT_ONE;
                end
            end
            S_LOCK: begin
                if (!ext_req) begin
                    // Requester went away: release without a beat.
                    state_d = S_ARB;
                end else if (!ext_lock) begin
                    // Final beat of the burst.
                    state_d = S_ARB;
                end else begin
                    burst_cnt_d = cnt_inc;
                    // Forced yield; last_owner is already EXT so a
                    // waiting core takes the next cycle.
                    if (cnt_inc == CNT_MAX) begin
                        state_d = S_ARB;
                    end
                end
            end
            default: begin
                state_d = S_ARB;
            end
        endcase
    end

    // ------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_ARB;
            last_owner_q   <= OWN_EXT;
            burst_cnt_q    <= '0;
            core_rd_pend_q <= 1'b0;
            ext_rd_pend_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            last_owner_q   <= last_owner_d;
            burst_cnt_q    <= burst_cnt_d;
            core_rd_pend_q <= core_rd_pend_d;
            ext_rd_pend_q  <= ext_rd_pend_d;
        end
    end

    // ------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------
    assign core_gnt    = core_win & ~rst;
    assign ext_gnt     = ext_win & ~rst;
    assign lock_active = (state_q == S_LOCK) & ~rst;
    assign core_stall  = core_req & ~core_gnt & ~rst;

    // Idle port keeps the core's address and data on the bus.
    assign mem_A  = ext_gnt ? ext_addr : core_addr;
    assign mem_W  = ext_gnt ? ext_wdata : core_wdata;
    assign mem_WE = core_gnt ? core_we :
                    ext_gnt  ? ext_we  : '0;

    assign core_rvalid = core_rd_pend_q & ~rst;
    assign ext_rvalid  = ext_rd_pend_q & ~rst;
    assign core_rdata  = core_rvalid ? mem_R : '0;
    assign ext_rdata   = ext_rvalid ? mem_R : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed vector table, hand sequences for burst
// yield and reset-in-lock, then random traffic against a spec model.

module tb_mem_port_arbiter;

    localparam int MB = 8;
    localparam logic Z = 1'b0;
    localparam logic O = 1'b1;
    localparam logic [31:0] CA = 32'h0000_0010;
    localparam logic [31:0] EA = 32'h0000_0020;
    localparam logic [31:0] CWD = 32'hCAFE_0000;
    localparam logic [31:0] EWD = 32'h1234_5678;
    localparam logic [31:0] RD = 32'hDEAD_BEEF;

    logic        clk;
    logic        rst;
    logic        core_req;
    logic [31:0] core_addr;
    logic [3:0]  core_we;
    logic [31:0] core_wdata;
    logic        core_gnt;
    logic        core_rvalid;
    logic [31:0] core_rdata;
    logic        ext_req;
    logic [31:0] ext_addr;
    logic [3:0]  ext_we;
    logic [31:0] ext_wdata;
    logic        ext_lock;
    logic        ext_gnt;
    logic        ext_rvalid;
    logic [31:0] ext_rdata;
    logic [31:0] mem_A;
    logic [3:0]  mem_WE;
    logic [31:0] mem_W;
    logic [31:0] mem_R;
    logic        lock_active;
    logic        core_stall;

    mem_port_arbiter #(
        .WORD_WIDTH(32),
        .WE_WIDTH(4),
        .MAX_BURST(MB)
    ) dut (
        .clk(clk),
        .rst(rst),
        .core_req(core_req),
        .core_addr(core_addr),
        .core_we(core_we),
        .core_wdata(core_wdata),
        .core_gnt(core_gnt),
        .core_rvalid(core_rvalid),
        .core_rdata(core_rdata),
        .ext_req(ext_req),
        .ext_addr(ext_addr),
        .ext_we(ext_we),
        .ext_wdata(ext_wdata),
        .ext_lock(ext_lock),
        .ext_gnt(ext_gnt),
        .ext_rvalid(ext_rvalid),
        .ext_rdata(ext_rdata),
        .mem_A(mem_A),
        .mem_WE(mem_WE),
        .mem_W(mem_W),
        .mem_R(mem_R),
        .lock_active(lock_active),
        .core_stall(core_stall)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Holds what the spec says is remembered between cycles.
    bit m_locked;
    int m_beats;
    bit m_last_ext;
    bit m_core_pend;
    bit m_ext_pend;
    bit e_cg;
    bit e_eg;

    task automatic model_comb();
        e_cg = 0;
        e_eg = 0;
        if (!rst) begin
            if (m_locked) begin
                e_eg = ext_req;
            end else if (core_req && ext_req) begin
                e_cg = m_last_ext;
                e_eg = !m_last_ext;
            end else begin
                e_cg = core_req;
                e_eg = ext_req;
            end
        end
    endtask

    task automatic model_seq();
        if (rst) begin
            m_locked = 0;
            m_beats = 0;
            m_last_ext = 1;
            m_core_pend = 0;
            m_ext_pend = 0;
        end else begin
            m_core_pend = e_cg && (core_we == 4'h0);
            m_ext_pend = e_eg && (ext_we == 4'h0);
            if (e_cg) m_last_ext = 0;
            if (e_eg) m_last_ext = 1;
            if (!m_locked) begin
                if (e_eg && ext_lock && MB > 1) begin
                    m_locked = 1;
                    m_beats = 1;
                end
            end else if (!e_eg || !ext_lock) begin
                m_locked = 0;
            end else begin
                m_beats++;
                if (m_beats == MB) m_locked = 0;
            end
        end
    endtask

    task automatic cmp_model();
        logic [3:0]  x_we;
        logic [31:0] x_a;
        logic [31:0] x_w;
        bit x_crv;
        bit x_erv;
        x_we = e_cg ? core_we : (e_eg ? ext_we : 4'h0);
        x_a = e_eg ? ext_addr : core_addr;
        x_w = e_eg ? ext_wdata : core_wdata;
        x_crv = m_core_pend && !rst;
        x_erv = m_ext_pend && !rst;
        chk("m_core_gnt", 64'(core_gnt), 64'(e_cg));
        chk("m_ext_gnt", 64'(ext_gnt), 64'(e_eg));
        chk("m_mem_WE", 64'(mem_WE), 64'(x_we));
        chk("m_mem_A", 64'(mem_A), 64'(x_a));
        chk("m_mem_W", 64'(mem_W), 64'(x_w));
        chk("m_core_rvalid", 64'(core_rvalid), 64'(x_crv));
        chk("m_ext_rvalid", 64'(ext_rvalid), 64'(x_erv));
        chk("m_core_rdata", 64'(core_rdata), 64'(x_crv ? mem_R : 32'h0));
        chk("m_ext_rdata", 64'(ext_rdata), 64'(x_erv ? mem_R : 32'h0));
        chk("m_lock_active", 64'(lock_active), 64'(m_locked && !rst));
        chk("m_core_stall", 64'(core_stall),
            64'(core_req && !e_cg && !rst));
    endtask

    task automatic tick();
        @(posedge clk);
        model_seq();
        #1;
    endtask

    task automatic step_model();
        @(negedge clk);
        model_comb();
        cmp_model();
        tick();
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        r;
        logic        cr;
        logic [3:0]  cwe;
        logic        er;
        logic [3:0]  ewe;
        logic        el;
        logic        cg;
        logic        eg;
        logic [3:0]  we;
        logic [31:0] a;
        logic [31:0] w;
        logic        crv;
        logic        erv;
        logic        la;
        logic        st;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic cr, input logic [3:0] cwe,
                       input logic er, input logic [3:0] ewe, input logic el,
                       input logic cg, input logic eg, input logic [3:0] we,
                       input logic [31:0] a, input logic [31:0] w,
                       input logic crv, input logic erv, input logic la,
                       input logic st);
        vec_t v;
        v.r = r; v.cr = cr; v.cwe = cwe; v.er = er; v.ewe = ewe; v.el = el;
        v.cg = cg; v.eg = eg; v.we = we; v.a = a; v.w = w;
        v.crv = crv; v.erv = erv; v.la = la; v.st = st;
        vecs.push_back(v);
    endtask

    string seq;
    int    ebeats;
    int    run;
    int    maxrun;
    bit    done;
    bit    c_wait;
    bit    e_wait;

    initial begin
        rst = 1'b1;
        core_req = 1'b0;
        core_addr = CA;
        core_we = 4'h0;
        core_wdata = CWD;
        ext_req = 1'b0;
        ext_addr = EA;
        ext_we = 4'h0;
        ext_wdata = EWD;
        ext_lock = 1'b0;
        mem_R = RD;
        m_locked = 0;
        m_beats = 0;
        m_last_ext = 1;
        m_core_pend = 0;
        m_ext_pend = 0;

        // reset with both requesting, then core read
        add(O,O,4'h0,O,4'h0,Z, Z,Z,4'h0,CA,CWD,Z,Z,Z,Z);
        add(O,O,4'h0,O,4'h0,Z, Z,Z,4'h0,CA,CWD,Z,Z,Z,Z);
        add(Z,O,4'h0,O,4'h0,Z, O,Z,4'h0,CA,CWD,Z,Z,Z,O ^ O);
        add(Z,Z,4'h0,Z,4'h0,Z, Z,Z,4'h0,CA,CWD,O,Z,Z,Z);
        // single ext read so core owns the next tie
        add(Z,Z,4'h0,O,4'h0,Z, Z,O,4'h0,EA,EWD,Z,Z,Z,Z);
        add(Z,Z,4'h0,Z,4'h0,Z, Z,Z,4'h0,CA,CWD,Z,O,Z,Z);
        // round robin C,E,C,E,C,E
        add(Z,O,4'h0,O,4'h0,Z, O,Z,4'h0,CA,CWD,Z,Z,Z,Z);
        add(Z,O,4'h0,O,4'h0,Z, Z,O,4'h0,EA,EWD,O,Z,Z,O);
        add(Z,O,4'h0,O,4'h0,Z, O,Z,4'h0,CA,CWD,Z,O,Z,Z);
        add(Z,O,4'h0,O,4'h0,Z, Z,O,4'h0,EA,EWD,O,Z,Z,O);
        add(Z,O,4'h0,O,4'h0,Z, O,Z,4'h0,CA,CWD,Z,O,Z,Z);
        add(Z,O,4'h0,O,4'h0,Z, Z,O,4'h0,EA,EWD,O,Z,Z,O);
        add(Z,Z,4'h0,Z,4'h0,Z, Z,Z,4'h0,CA,CWD,Z,O,Z,Z);
        // ext write, no rvalid after
        add(Z,Z,4'h0,O,4'hF,Z, Z,O,4'hF,EA,EWD,Z,Z,Z,Z);
        add(Z,Z,4'h0,Z,4'h0,Z, Z,Z,4'h0,CA,CWD,Z,Z,Z,Z);
        // core partial write
        add(Z,O,4'h3,Z,4'h0,Z, O,Z,4'h3,CA,CWD,Z,Z,Z,Z);
        add(Z,Z,4'h0,Z,4'h0,Z, Z,Z,4'h0,CA,CWD,Z,Z,Z,Z);

        foreach (vecs[i]) begin
            rst = vecs[i].r;
            core_req = vecs[i].cr;
            core_we = vecs[i].cwe;
            ext_req = vecs[i].er;
            ext_we = vecs[i].ewe;
            ext_lock = vecs[i].el;
            @(negedge clk);
            model_comb();
            chk($sformatf("v%0d_core_gnt", i), 64'(core_gnt), 64'(vecs[i].cg));
            chk($sformatf("v%0d_ext_gnt", i), 64'(ext_gnt), 64'(vecs[i].eg));
            chk($sformatf("v%0d_mem_WE", i), 64'(mem_WE), 64'(vecs[i].we));
            chk($sformatf("v%0d_mem_A", i), 64'(mem_A), 64'(vecs[i].a));
            chk($sformatf("v%0d_mem_W", i), 64'(mem_W), 64'(vecs[i].w));
            chk($sformatf("v%0d_core_rvalid", i), 64'(core_rvalid),
                64'(vecs[i].crv));
            chk($sformatf("v%0d_ext_rvalid", i), 64'(ext_rvalid),
                64'(vecs[i].erv));
            chk($sformatf("v%0d_core_rdata", i), 64'(core_rdata),
                64'(vecs[i].crv ? RD : 32'h0));
            chk($sformatf("v%0d_ext_rdata", i), 64'(ext_rdata),
                64'(vecs[i].erv ? RD : 32'h0));
            chk($sformatf("v%0d_lock_active", i), 64'(lock_active),
                64'(vecs[i].la));
            chk($sformatf("v%0d_core_stall", i), 64'(core_stall),
                64'(vecs[i].st));
            tick();
        end

        // ---------------- forced yield ----------------
        rst = 1'b0;
        core_req = 1'b1;
        core_we = 4'h0;
        ext_req = 1'b0;
        ext_lock = 1'b0;
        ext_we = 4'h0;
        step_model();
        ext_req = 1'b1;
        ext_lock = 1'b1;
        seq = "";
        ebeats = 0;
        run = 0;
        maxrun = 0;
        done = 0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            model_comb();
            cmp_model();
            if (core_gnt) seq = {seq, "C"};
            if (ext_gnt) seq = {seq, "E"};
            if (ext_gnt) ebeats++;
            if (core_stall) run++;
            else run = 0;
            if (run > maxrun) maxrun = run;
            if (core_gnt && ebeats == 12) done = 1;
            tick();
            ext_req = (ebeats < 12);
            ext_lock = (ebeats + 1 < 12);
        end
        n_tests++;
        if (!done || seq != "EEEEEEEECEEEEC") begin
            n_fail++;
            $display("FAIL yield_seq: got %s expected EEEEEEEECEEEEC", seq);
        end
        chk("yield_max_stall", 64'(maxrun), 64'd8);

        // ---------------- reset during lock ----------------
        core_req = 1'b0;
        ext_req = 1'b0;
        ext_lock = 1'b0;
        step_model();
        ext_req = 1'b1;
        ext_lock = 1'b1;
        ext_we = 4'h0;
        step_model();
        @(negedge clk);
        model_comb();
        cmp_model();
        chk("rl_locked_b2", 64'(lock_active), 64'd1);
        tick();
        rst = 1'b1;
        @(negedge clk);
        model_comb();
        cmp_model();
        chk("rl_rst_ext_gnt", 64'(ext_gnt), 64'd0);
        chk("rl_rst_ext_rvalid", 64'(ext_rvalid), 64'd0);
        tick();
        rst = 1'b0;
        core_req = 1'b1;
        @(negedge clk);
        model_comb();
        cmp_model();
        chk("rl_after_lock", 64'(lock_active), 64'd0);
        chk("rl_after_rvalid", 64'(ext_rvalid), 64'd0);
        chk("rl_after_core_gnt", 64'(core_gnt), 64'd1);
        tick();

        // ---------------- random traffic ----------------
        c_wait = 0;
        e_wait = 0;
        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(0, 59) == 0);
            if (c_wait && $urandom_range(0, 9) != 0) begin
                core_req = 1'b1;
            end else begin
                core_req = ($urandom_range(0, 2) != 0);
                core_addr = $urandom;
                core_wdata = $urandom;
                core_we = $urandom_range(0, 1) ? 4'h0 : 4'($urandom);
            end
            if (e_wait && $urandom_range(0, 9) != 0) begin
                ext_req = 1'b1;
            end else begin
                ext_req = ($urandom_range(0, 3) != 0);
                ext_addr = $urandom;
                ext_wdata = $urandom;
                ext_we = $urandom_range(0, 1) ? 4'h0 : 4'($urandom);
                ext_lock = ($urandom_range(0, 4) != 0);
            end
            mem_R = $urandom;
            step_model();
            c_wait = core_req && !e_cg;
            e_wait = ext_req && !e_eg;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
